// File: rtl/bus_block_mover.sv
// Bus-master copy engine: reads LEN 64-bit words from SRC and writes them to DST
// through a small read-data FIFO, one registered request per cycle.
module bus_block_mover #(
    parameter logic [4:0] UNIT_ID = 5'd1,
    parameter int         DEPTH   = 8
) (
    input  logic        CLKH,
    input  logic        RESET,
    input  logic        START,
    input  logic [31:0] SRC,
    input  logic [31:0] DST,
    input  logic [15:0] LEN,
    output logic        BUSY,
    output logic        DONE,
    input  logic        NEXT,
    output logic        ACT,
    output logic        CMD,
    output logic [31:0] ADDR,
    output logic [7:0]  BE,
    output logic [63:0] DTO,
    output logic [20:0] TAGO,
    input  logic        DRDY,
    input  logic [63:0] DTI,
    input  logic [20:0] TAGI
);

    // state   | meaning
    // IDLE    | waiting for START
    // RUN     | issuing reads/writes until the last write is accepted
    // DONE    | one-cycle completion pulse
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int UW = CW + 1;

    state_t         state_q, state_d;
    logic           busy_q, busy_d;
    logic [31:0]    src_q, src_d;
    logic [31:0]    dst_q, dst_d;
    logic [15:0]    len_q, len_d;
    logic [15:0]    rcount_q, rcount_d;
    logic [15:0]    wcount_q, wcount_d;
    logic [CW-1:0]  outst_q, outst_d;
    logic [CW-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic           act_q, act_d;
    logic           cmd_q, cmd_d;
    logic [31:0]    addr_q, addr_d;
    logic [7:0]     be_q, be_d;
    logic [63:0]    dto_q, dto_d;
    logic [20:0]    tago_q, tago_d;
    logic [63:0]    mem_q [DEPTH];

    logic           rsp_hit;
    logic           push;
    logic           pop;
    logic           issue_rd;
    logic           fifo_avail;
    logic [63:0]    head;
    logic [UW-1:0]  used;
    logic           credit;
    logic           can_sel;
    logic           last_wr_acc;
    logic           unused_bits;

    assign unused_bits = ^{SRC[2:0], DST[2:0], TAGI[15:0]};

    assign rsp_hit     = DRDY && (TAGI[20:16] == UNIT_ID) && (state_q == ST_RUN);
    assign push        = rsp_hit && (fifo_cnt_q != CW'(DEPTH));
    // An arriving response can be forwarded straight into a write in the same cycle.
    assign fifo_avail  = (fifo_cnt_q != '0) || push;
    assign head        = (fifo_cnt_q != '0) ? mem_q[rd_ptr_q] : DTI;
    assign used        = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
    assign credit      = used < UW'(DEPTH);
    assign can_sel     = !act_q || NEXT;
    assign last_wr_acc = act_q && NEXT && !cmd_q && (wcount_q == len_q);

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        rcount_d = rcount_q;
        wcount_d = wcount_q;
        act_d    = act_q;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        be_d     = be_q;
        dto_d    = dto_q;
        tago_d   = tago_q;
        pop      = 1'b0;
        issue_rd = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    src_d    = {SRC[31:3], 3'b000};
                    dst_d    = {DST[31:3], 3'b000};
                    len_d    = LEN;
                    rcount_d = 16'd0;
                    wcount_d = 16'd0;
                    if (LEN == 16'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_RUN;
                        busy_d   = 1'b1;
                        act_d    = 1'b1;
                        cmd_d    = 1'b1;
                        addr_d   = {SRC[31:3], 3'b000};
                        be_d     = 8'hFF;
                        tago_d   = {UNIT_ID, 16'd0};
                        rcount_d = 16'd1;
                        issue_rd = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (last_wr_acc) begin
                    state_d = ST_DONE;
                    act_d   = 1'b0;
                end else if (can_sel) begin
                    if (fifo_avail) begin
                        act_d    = 1'b1;
                        cmd_d    = 1'b0;
                        addr_d   = dst_q + {13'd0, wcount_q, 3'd0};
                        be_d     = 8'h00;
                        dto_d    = head;
                        tago_d   = {UNIT_ID, wcount_q};
                        wcount_d = wcount_q + 16'd1;
                        pop      = 1'b1;
                    end else if ((rcount_q < len_q) && credit) begin
                        act_d    = 1'b1;
                        cmd_d    = 1'b1;
                        addr_d   = src_q + {13'd0, rcount_q, 3'd0};
                        be_d     = 8'hFF;
                        tago_d   = {UNIT_ID, rcount_q};
                        rcount_d = rcount_q + 16'd1;
                        issue_rd = 1'b1;
                    end else begin
                        act_d = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        outst_d    = outst_q + CW'(issue_rd) - CW'(rsp_hit);
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
    end

    always_ff @(posedge CLKH or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            rcount_q   <= '0;
            wcount_q   <= '0;
            outst_q    <= '0;
            fifo_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            act_q      <= 1'b0;
            cmd_q      <= 1'b0;
            addr_q     <= '0;
            be_q       <= 8'hFF;
            dto_q      <= '0;
            tago_q     <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            rcount_q   <= rcount_d;
            wcount_q   <= wcount_d;
            outst_q    <= outst_d;
            fifo_cnt_q <= fifo_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            act_q      <= act_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            dto_q      <= dto_d;
            tago_q     <= tago_d;
        end
    end

    always_ff @(posedge CLKH) begin
        if (push) mem_q[wr_ptr_q] <= DTI;
    end

    assign BUSY = busy_q;
    assign DONE = (state_q == ST_DONE);
    assign ACT  = act_q;
    assign CMD  = cmd_q;
    assign ADDR = addr_q;
    assign BE   = be_q;
    assign DTO  = dto_q;
    assign TAGO = tago_q;

endmodule

// File: tb/tb_bus_block_mover.sv
// Directed bench for bus_block_mover with a 2-cycle memory responder model.
module tb_bus_block_mover;

    logic        CLKH  = 1'b0;
    logic        RESET = 1'b0;
    logic        START = 1'b0;
    logic [31:0] SRC   = '0;
    logic [31:0] DST   = '0;
    logic [15:0] LEN   = '0;
    logic        BUSY, DONE, ACT, CMD;
    logic        NEXT  = 1'b1;
    logic [31:0] ADDR;
    logic [7:0]  BE;
    logic [63:0] DTO;
    logic [20:0] TAGO;
    logic        DRDY  = 1'b0;
    logic [63:0] DTI   = '0;
    logic [20:0] TAGI  = '0;

    bus_block_mover #(.UNIT_ID(5'd1), .DEPTH(8)) dut (
        .CLKH(CLKH), .RESET(RESET), .START(START), .SRC(SRC), .DST(DST), .LEN(LEN),
        .BUSY(BUSY), .DONE(DONE), .NEXT(NEXT), .ACT(ACT), .CMD(CMD), .ADDR(ADDR),
        .BE(BE), .DTO(DTO), .TAGO(TAGO), .DRDY(DRDY), .DTI(DTI), .TAGI(TAGI)
    );

    always #5 CLKH = ~CLKH;

    int cyc = 0;
    always @(posedge CLKH) cyc <= cyc + 1;

    int vectors = 0;
    int errors  = 0;

    logic [63:0] src_mem [logic [31:0]];
    logic [31:0] rq_addr [$];
    logic [20:0] rq_tag  [$];
    logic [31:0] wq_addr [$];
    logic [63:0] wq_data [$];

    int stall_err = 0, be_err = 0, reads_acc = 0, writes_acc = 0, max_level = 0;
    int act_cnt = 0, done_cnt = 0, last_wr_edge = -1, foreign_sent = 0, level = 0;
    int clr_token = 0, clr_seen = 0, foreign_token = 0, foreign_seen = 0;
    bit next_random = 1'b0;
    bit prev_stall = 1'b0;
    logic [126:0] prev_fields = '0;
    logic        s1_v = 1'b0, s2_v = 1'b0;
    logic [63:0] s1_d = '0, s2_d = '0;
    logic [20:0] s1_t = '0, s2_t = '0;

    // Responder/monitor: acts on the falling edge, read data returns two rising edges after acceptance.
    always @(negedge CLKH) begin
        if (clr_token != clr_seen) begin
            clr_seen = clr_token;
            rq_addr.delete(); rq_tag.delete(); wq_addr.delete(); wq_data.delete();
            stall_err = 0; be_err = 0; reads_acc = 0; writes_acc = 0; max_level = 0;
            act_cnt = 0; done_cnt = 0; last_wr_edge = -1; foreign_sent = 0; prev_stall = 1'b0;
        end
        if (s2_v) begin
            DRDY = 1'b1; DTI = s2_d; TAGI = s2_t;
        end else if (foreign_token != foreign_seen) begin
            foreign_seen = foreign_token;
            foreign_sent++;
            DRDY = 1'b1; DTI = 64'hBAD0_BAD0_BAD0_BAD0; TAGI = {5'd2, 16'h0001};
        end else begin
            DRDY = 1'b0; DTI = '0; TAGI = '0;
        end
        s2_v = s1_v; s2_d = s1_d; s2_t = s1_t; s1_v = 1'b0;
        NEXT = next_random ? 1'($urandom_range(1, 0)) : 1'b1;
        if (RESET) begin
            if (prev_stall && ({ACT, CMD, ADDR, BE, DTO, TAGO} !== prev_fields)) stall_err++;
            prev_stall  = ACT && !NEXT;
            prev_fields = {ACT, CMD, ADDR, BE, DTO, TAGO};
            if (ACT) act_cnt++;
            if (DONE) done_cnt++;
            level = reads_acc - writes_acc + ((ACT && CMD) ? 1 : 0) - ((ACT && !CMD) ? 1 : 0);
            if (level > max_level) max_level = level;
            if (ACT && NEXT) begin
                if (CMD) begin
                    rq_addr.push_back(ADDR); rq_tag.push_back(TAGO);
                    s1_v = 1'b1;
                    s1_d = src_mem.exists(ADDR) ? src_mem[ADDR] : 64'hDEAD_BEEF_DEAD_BEEF;
                    s1_t = TAGO;
                    reads_acc++;
                    if (BE !== 8'hFF) be_err++;
                end else begin
                    wq_addr.push_back(ADDR); wq_data.push_back(DTO);
                    writes_acc++;
                    last_wr_edge = cyc + 1;
                    if (BE !== 8'h00) be_err++;
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic clear_stats();
        clr_token++;
        @(posedge CLKH); #1;
    endtask

    task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                              output int start_edge);
        SRC = s; DST = d; LEN = l; START = 1'b1;
        @(posedge CLKH); #1;
        START = 1'b0;
        start_edge = cyc;
    endtask

    task automatic wait_done(input int budget, output int done_edge, output bit ok);
        ok = 1'b0; done_edge = -1;
        for (int i = 0; i < budget; i++) begin
            if (DONE === 1'b1) begin ok = 1'b1; done_edge = cyc; break; end
            @(posedge CLKH); #1;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b0; START = 1'b0;
        repeat (3) @(posedge CLKH);
        #1;
        vectors++; if ({ACT, CMD, BUSY, DONE} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl: got %b expected 0000", {ACT, CMD, BUSY, DONE}); end
        vectors++; if (ADDR !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", ADDR); end
        vectors++; if (BE !== 8'hFF) begin errors++; $display("FAIL reset_be: got %h expected ff", BE); end
        vectors++; if (DTO !== 64'h0) begin errors++; $display("FAIL reset_dto: got %h expected 0", DTO); end
        vectors++; if (TAGO !== 21'h0) begin errors++; $display("FAIL reset_tago: got %h expected 0", TAGO); end
        RESET = 1'b1;
        @(posedge CLKH); #1;
        vectors++; if ({ACT, BUSY} !== 2'b00) begin errors++; $display("FAIL reset_release: got %b expected 00", {ACT, BUSY}); end
    endtask

    task automatic test_basic();
        int n, d;
        bit ok;
        logic [63:0] pat [4];
        pat[0] = 64'h1111_1111_1111_1111; pat[1] = 64'h2222_2222_2222_2222;
        pat[2] = 64'h3333_3333_3333_3333; pat[3] = 64'h4444_4444_4444_4444;
        for (int i = 0; i < 4; i++) src_mem[32'(8 * i)] = pat[i];
        next_random = 1'b0;
        clear_stats();
        start_copy(32'h0, 32'h8000, 16'd4, n);
        vectors++; if ({BUSY, ACT, CMD} !== 3'b111) begin errors++; $display("FAIL basic_first_req: got %b expected 111", {BUSY, ACT, CMD}); end
        vectors++; if (ADDR !== 32'h0 || TAGO !== 21'h10000) begin errors++; $display("FAIL basic_first_addr: got %h/%h expected 0/10000", ADDR, TAGO); end
        wait_done(60, d, ok);
        vectors++; if (!ok) begin errors++; $display("FAIL basic_done_timeout: got none expected DONE within 60 cycles"); end
        vectors++; if (d - n !== 10) begin errors++; $display("FAIL basic_latency: got %0d expected 10", d - n); end
        vectors++; if (d !== last_wr_edge) begin errors++; $display("FAIL basic_done_after_last_write: got edge %0d expected %0d", d, last_wr_edge); end
        vectors++; if ({ACT, BUSY} !== 2'b01) begin errors++; $display("FAIL basic_done_cycle: got act/busy %b expected 01", {ACT, BUSY}); end
        @(posedge CLKH); #1;
        vectors++; if ({BUSY, DONE} !== 2'b00) begin errors++; $display("FAIL basic_busy_fall: got %b expected 00", {BUSY, DONE}); end
        repeat (3) @(posedge CLKH);
        #1;
        vectors++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt); end
        vectors++; if (rq_addr.size() !== 4 || wq_addr.size() !== 4) begin errors++; $display("FAIL basic_counts: got %0d/%0d expected 4/4", rq_addr.size(), wq_addr.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < rq_addr.size()) begin
                vectors++; if (rq_addr[i] !== 32'(8 * i) || rq_tag[i] !== 21'h10000 + 21'(i)) begin errors++; $display("FAIL basic_read%0d: got %h/%h expected %h/%h", i, rq_addr[i], rq_tag[i], 32'(8 * i), 21'h10000 + 21'(i)); end
            end
            if (i < wq_addr.size()) begin
                vectors++; if (wq_addr[i] !== 32'h8000 + 32'(8 * i) || wq_data[i] !== pat[i]) begin errors++; $display("FAIL basic_write%0d: got %h/%h expected %h/%h", i, wq_addr[i], wq_data[i], 32'h8000 + 32'(8 * i), pat[i]); end
            end
        end
        vectors++; if (be_err !== 0) begin errors++; $display("FAIL basic_be: got %0d bad enables expected 0", be_err); end
    endtask

    task automatic test_zero_len();
        int n;
        clear_stats();
        start_copy(32'h100, 32'h200, 16'd0, n);
        vectors++; if ({DONE, BUSY, ACT} !== 3'b100) begin errors++; $display("FAIL zero_first_cycle: got %b expected 100", {DONE, BUSY, ACT}); end
        @(posedge CLKH); #1;
        vectors++; if ({DONE, BUSY, ACT} !== 3'b000) begin errors++; $display("FAIL zero_second_cycle: got %b expected 000", {DONE, BUSY, ACT}); end
        repeat (3) @(posedge CLKH);
        #1;
        vectors++; if (act_cnt !== 0 || done_cnt !== 1) begin errors++; $display("FAIL zero_activity: got act %0d done %0d expected 0 1", act_cnt, done_cnt); end
    endtask

    task automatic test_backpressure();
        int n, d;
        bit ok;
        for (int i = 0; i < 32; i++) src_mem[32'h1000 + 32'(8 * i)] = {$urandom(), $urandom()};
        next_random = 1'b1;
        clear_stats();
        start_copy(32'h1000, 32'h20000, 16'd32, n);
        wait_done(2000, d, ok);
        next_random = 1'b0;
        vectors++; if (!ok) begin errors++; $display("FAIL bp_done_timeout: got none expected DONE within 2000 cycles"); end
        vectors++; if (stall_err !== 0) begin errors++; $display("FAIL bp_stall_stable: got %0d changes expected 0", stall_err); end
        vectors++; if (max_level > 8) begin errors++; $display("FAIL bp_credit: got %0d expected <= 8", max_level); end
        vectors++; if (wq_addr.size() !== 32 || rq_addr.size() !== 32) begin errors++; $display("FAIL bp_counts: got %0d/%0d expected 32/32", rq_addr.size(), wq_addr.size()); end
        for (int i = 0; i < 32 && i < wq_addr.size(); i++) begin
            vectors++;
            if (wq_addr[i] !== 32'h20000 + 32'(8 * i) || wq_data[i] !== src_mem[32'h1000 + 32'(8 * i)]) begin
                errors++; $display("FAIL bp_write%0d: got %h/%h expected %h/%h", i, wq_addr[i], wq_data[i], 32'h20000 + 32'(8 * i), src_mem[32'h1000 + 32'(8 * i)]);
            end
        end
        repeat (2) @(posedge CLKH);
        #1;
    endtask

    task automatic test_foreign_wrap();
        int n, d;
        bit ok;
        logic [31:0] ea [3];
        logic [63:0] ed [3];
        ea[0] = 32'hFFFF_FFF0; ea[1] = 32'hFFFF_FFF8; ea[2] = 32'h0000_0000;
        ed[0] = 64'hA5A5_0000_0000_0001; ed[1] = 64'hA5A5_0000_0000_0002; ed[2] = 64'hA5A5_0000_0000_0003;
        for (int i = 0; i < 3; i++) src_mem[ea[i]] = ed[i];
        clear_stats();
        start_copy(32'hFFFF_FFF4, 32'h4000, 16'd3, n);
        foreign_token++;
        wait_done(60, d, ok);
        vectors++; if (!ok) begin errors++; $display("FAIL wrap_done_timeout: got none expected DONE within 60 cycles"); end
        vectors++; if (foreign_sent !== 1) begin errors++; $display("FAIL wrap_foreign_injected: got %0d expected 1", foreign_sent); end
        vectors++; if (rq_addr.size() !== 3 || wq_addr.size() !== 3) begin errors++; $display("FAIL wrap_counts: got %0d/%0d expected 3/3", rq_addr.size(), wq_addr.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < rq_addr.size()) begin
                vectors++; if (rq_addr[i] !== ea[i]) begin errors++; $display("FAIL wrap_read%0d: got %h expected %h", i, rq_addr[i], ea[i]); end
            end
            if (i < wq_addr.size()) begin
                vectors++; if (wq_addr[i] !== 32'h4000 + 32'(8 * i) || wq_data[i] !== ed[i]) begin errors++; $display("FAIL wrap_write%0d: got %h/%h expected %h/%h", i, wq_addr[i], wq_data[i], 32'h4000 + 32'(8 * i), ed[i]); end
            end
        end
        repeat (2) @(posedge CLKH);
        #1;
    endtask

    task automatic test_reset_mid_copy();
        int n, d;
        bit ok;
        for (int i = 0; i < 16; i++) src_mem[32'h2000 + 32'(8 * i)] = 64'hC0DE_0000_0000_0000 + 64'(i);
        clear_stats();
        start_copy(32'h2000, 32'h6000, 16'd16, n);
        repeat (9) @(posedge CLKH);
        #1;
        RESET = 1'b0;
        #1;
        vectors++; if ({ACT, CMD, BUSY, DONE} !== 4'b0000) begin errors++; $display("FAIL midrst_ctrl: got %b expected 0000", {ACT, CMD, BUSY, DONE}); end
        vectors++; if (ADDR !== 32'h0 || BE !== 8'hFF || DTO !== 64'h0 || TAGO !== 21'h0) begin errors++; $display("FAIL midrst_fields: got %h/%h/%h/%h expected 0/ff/0/0", ADDR, BE, DTO, TAGO); end
        #2;
        RESET = 1'b1;
        @(posedge CLKH); #1;
        clear_stats();
        repeat (4) @(posedge CLKH);
        #1;
        vectors++; if (act_cnt !== 0 || BUSY !== 1'b0) begin errors++; $display("FAIL midrst_idle: got act %0d busy %b expected 0 0", act_cnt, BUSY); end
        clear_stats();
        start_copy(32'h2000, 32'h7000, 16'd2, n);
        wait_done(60, d, ok);
        vectors++; if (!ok) begin errors++; $display("FAIL midrst_done_timeout: got none expected DONE within 60 cycles"); end
        vectors++; if (wq_addr.size() !== 2) begin errors++; $display("FAIL midrst_count: got %0d expected 2", wq_addr.size()); end
        for (int i = 0; i < 2 && i < wq_addr.size(); i++) begin
            vectors++;
            if (wq_addr[i] !== 32'h7000 + 32'(8 * i) || wq_data[i] !== 64'hC0DE_0000_0000_0000 + 64'(i)) begin
                errors++; $display("FAIL midrst_write%0d: got %h/%h expected %h/%h", i, wq_addr[i], wq_data[i], 32'h7000 + 32'(8 * i), 64'hC0DE_0000_0000_0000 + 64'(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_backpressure();
        test_foreign_wrap();
        test_reset_mid_copy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/bus_block_mover.md
# bus_block_mover

Initiator-side copy engine for the 64-bit tagged request/response memory bus used by the on-chip BIOS RAM and the other memory responders. On one START it reads LEN 64-bit words from SRC and writes them to DST on the same bus port. It sits beside the processor as a bus master, typically to relocate the kernel image out of BIOS RAM. It uses the same signal set as the responders, seen from the other end.

## Interface
- UNIT_ID, 5'd1: value driven on TAGO[20:16]; responses with any other TAGI[20:16] are ignored.
- DEPTH, 8: read-data FIFO depth in words, power of two, 4..32.
- CLKH  in  1  clock; all logic on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle request; sampled only in IDLE.
- SRC  in  32  source byte address; bits [2:0] ignored and forced to 0.
- DST  in  32  destination byte address; bits [2:0] ignored and forced to 0.
- LEN  in  16  word count; 0 is legal.
- BUSY  out  1  high from the cycle after START is accepted until DONE.
- DONE  out  1  one-cycle pulse when the last write is accepted, or when LEN=0.
- NEXT  in  1  responder ready; a request is accepted on a cycle with ACT & NEXT.
- ACT  out  1  request valid.
- CMD  out  1  1 = read, 0 = write.
- ADDR  out  32  word-aligned byte address.
- BE  out  8  byte enables, active-low: 8'h00 on writes, 8'hFF on reads.
- DTO  out  64  write data.
- TAGO  out  21  {UNIT_ID, word index[15:0]}.
- DRDY  in  1  read data valid.
- DTI  in  64  read data.
- TAGI  in  21  returned tag.

## Operation
- States:
  - IDLE → RUN on START with LEN≠0.
  - IDLE → DONE on START with LEN=0. No bus activity occurs in this case.
  - RUN → DONE on acceptance of the last write.
  - DONE → IDLE unconditionally, after one cycle. DONE is high in this state.
- START latches SRC, DST and LEN into internal counters. START while BUSY is ignored.
- Request selection in RUN is registered, one request per cycle:
  - Write has priority whenever the FIFO is non-empty. It pops the FIFO head and sends it to DST + 8·wcount.
  - Otherwise, a read is issued if rcount < LEN and outstanding + fifo_count < DEPTH. The read goes to SRC + 8·rcount with tag index = rcount.
- Response acceptance:
  - DRDY with TAGI[20:16]==UNIT_ID pushes DTI into the FIFO and decrements outstanding.
  - DRDY with a foreign tag is ignored and does not affect outstanding.
- Responses arrive in issue order. The tag index is carried for debug only.
- The credit rule above guarantees the FIFO never overflows. If a push to a full FIFO still occurs, it is dropped; this is a bench error condition.
- Address arithmetic is 32-bit modulo; address wrap-around from 32'hFFFF_FFF8 goes to 0.
- Counters are 16 bits wide; LEN=16'hFFFF is legal.
- Writes produce no DRDY.

## Timing
- Reset values:
  - Outputs: ACT=0, CMD=0, ADDR=0, BE=8'hFF, DTO=0, TAGO=0, BUSY=0, DONE=0.
  - Internal: state IDLE, FIFO empty, all counters 0.
- An asserted RESET mid-copy aborts at once. Outstanding responses arriving after release are ignored, because their DRDY falls in IDLE.
- START accepted at edge N:
  - BUSY=1 and the first read has ACT=1 from cycle N+1.
  - With LEN=0, DONE=1 in cycle N+1 and BUSY stays 0.
- While ACT=1 and NEXT=0: ACT, CMD, ADDR, BE, DTO and TAGO hold stable until accepted.
- Throughput:
  - With NEXT held high, one request is accepted per cycle.
  - Against a 2-cycle responder (DRDY two edges after read acceptance), a FIFO push at edge M allows the write to be presented in cycle M+1.
- The last write is accepted at edge K:
  - DONE=1 and ACT=0 in cycle K+1.
  - BUSY=0 from cycle K+2.
- DRDY coinciding with a write pop: the FIFO performs the push and the pop in the same cycle, and its count is unchanged.

## Test plan
- Reset mid-copy:
  - Stimulus: LEN=16, RESET low at cycle 10, released, then a new START with LEN=2.
  - Required response: all outputs at reset values during reset; late DRDYs ignored; the second copy completes correctly.
- Basic copy:
  - Stimulus: 2-cycle BIOS RAM model with NEXT=1; SRC=0x0, DST=0x8000, LEN=4, source words 0x1111…, 0x2222…, 0x3333…, 0x4444….
  - Required response: 4 reads to 0x0/0x8/0x10/0x18 with TAGO=0x10000..0x10003; writes to 0x8000..0x8018 carry the same data with BE=8'h00; one DONE pulse; BUSY falls after DONE.
- Zero length:
  - Stimulus: START with LEN=0.
  - Required response: DONE=1 the next cycle, ACT never asserted, BUSY stays 0.
- Backpressure:
  - Stimulus: LEN=32, NEXT random at 50%.
  - Required response: request fields stable while stalled; outstanding+fifo never exceeds 8; destination contents equal the source.
- Foreign tags and wrap-around:
  - Stimulus: inject DRDY with TAGI[20:16]=5'd2 mid-copy; SRC=32'hFFFF_FFF0, LEN=3.
  - Required response: foreign data not written; read addresses 0xFFFFFFF0, 0xFFFFFFF8, 0x0.
